qspi_rd_bridge: RTL

Parametrised QSPI read-slave front end for the qspi2sdram path. It decodes Fast Read (0Bh, 1-1-1) and Fast Read Quad Output (6Bh, 1-1-4) from the host and captures the address. It issues a read request toward the SDRAM side, then streams a burst of words popped from the SDRAM read FIFO onto one or four IO lines. It adds csn-framed transactions, quad output, a request/busy handshake and underrun reporting.

---
 rtl/qspi_rd_bridge.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/qspi_rd_bridge.sv
// qspi_rd_bridge: QSPI read-slave front end for the qspi2sdram path.
// Decodes Fast Read (0Bh, single output) and Fast Read Quad Output (6Bh),
// captures the address, raises a read request toward the SDRAM side and then
// streams RD_BL words popped from a show-ahead FIFO onto one or four IO lines.
module qspi_rd_bridge #(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 16,
   parameter int RD_BL     = 2,
   parameter int DUMMY_CYC = 8
) (
   input  logic              qspi_clk,
   input  logic              rst_n,
   input  logic              csn,
   input  logic [3:0]        io_i,
   output logic [3:0]        io_o,
   output logic [3:0]        io_oe,
   output logic [ADDR_W-1:0] qspi_rd_addr,
   output logic              qspi_rd_req,
   input  logic              qspi_rd_busy,
   output logic              fifo_ren,
   input  logic              fifo_rempty,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              underrun
);

   // Counter must reach the longest phase: address, dummy or a single-mode word.
   localparam int MAX_A  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int MAX_B  = (MAX_A > DUMMY_CYC) ? MAX_A : DUMMY_CYC;
   localparam int CNT_W  = $clog2(MAX_B + 1);
   localparam int WC_W   = (RD_BL > 1) ? $clog2(RD_BL) : 1;
   localparam int WL_S   = DATA_W;
   localparam int WL_Q   = DATA_W / 4;

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_IGNORE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WC_W-1:0]     wcnt_q, wcnt_d;
   logic [ADDR_W-2:0]   sr_q, sr_d;
   logic [ADDR_W-1:0]   cur;
   logic                quad_q, quad_d;
   logic [DATA_W-1:0]   out_sr_q, out_sr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                req_q, req_d;
   logic                reload;
   logic                last_bit;

   // Only io_i[0] carries command and address in both supported commands.
   logic                unused_io;
   assign unused_io = ^io_i[3:1];

   // Next-state logic: phase sequencing, address capture, request handshake and word reloads.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      wcnt_d   = wcnt_q;
      quad_d   = quad_q;
      out_sr_d = out_sr_q;
      addr_d   = addr_q;
      req_d    = req_q;
      reload   = 1'b0;
      cur      = {sr_q, io_i[0]};
      sr_d     = cur[ADDR_W-2:0];
      last_bit = quad_q ? (cnt_q == CNT_W'(WL_Q - 1)) : (cnt_q == CNT_W'(WL_S - 1));

      // Request drops on the first cycle the SDRAM side is free to take it.
      if (req_q && !qspi_rd_busy) begin
         req_d = 1'b0;
      end

      if (csn) begin
         // Deselect aborts everything; the next selection starts a fresh command.
         state_d = S_CMD;
         cnt_d   = '0;
         wcnt_d  = '0;
         req_d   = 1'b0;
      end else begin
         case (state_q)
            S_CMD: begin
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d = '0;
                  if (cur[7:0] == 8'h0B) begin
                     state_d = S_ADDR;
                     quad_d  = 1'b0;
                  end else if (cur[7:0] == 8'h6B) begin
                     state_d = S_ADDR;
                     quad_d  = 1'b1;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
            end
            S_ADDR: begin
               if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                  addr_d  = cur;
                  req_d   = 1'b1;
                  state_d = S_DUMMY;
                  cnt_d   = '0;
               end
            end
            S_DUMMY: begin
               if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                  reload  = 1'b1;
                  wcnt_d  = '0;
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               out_sr_d = quad_q ? (out_sr_q << 4) : (out_sr_q << 1);
               // cnt tracks the clock within the current word here.
               if (last_bit) begin
                  cnt_d = '0;
                  if (wcnt_q == WC_W'(RD_BL - 1)) begin
                     state_d = S_IGNORE;
                  end else begin
                     reload = 1'b1;
                     wcnt_d = wcnt_q + WC_W'(1);
                  end
               end
            end
            S_IGNORE: begin
               cnt_d = cnt_q;
            end
            default: begin
               state_d = S_CMD;
               cnt_d   = '0;
            end
         endcase
      end

      // A reload pops the FIFO head, or substitutes zeros and flags an underrun.
      fifo_ren = reload && !fifo_rempty;
      underrun = reload && fifo_rempty;
      if (reload) begin
         out_sr_d = fifo_rempty ? '0 : fifo_rdata;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge qspi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_CMD;
         cnt_q    <= '0;
         wcnt_q   <= '0;
         sr_q     <= '0;
         quad_q   <= 1'b0;
         out_sr_q <= '0;
         addr_q   <= '0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wcnt_q   <= wcnt_d;
         sr_q     <= sr_d;
         quad_q   <= quad_d;
         out_sr_q <= out_sr_d;
         addr_q   <= addr_d;
         req_q    <= req_d;
      end
   end

   // IO drive decoded from registered state: MSB of the output shifter, on IO1 or IO3..IO0.
   always_comb begin
      io_o  = 4'b0000;
      io_oe = 4'b0000;
      if (state_q == S_DATA) begin
         if (quad_q) begin
            io_o  = out_sr_q[DATA_W-1 -: 4];
            io_oe = 4'b1111;
         end else begin
            io_o[1] = out_sr_q[DATA_W-1];
            io_oe   = 4'b0010;
         end
      end
   end

   assign qspi_rd_addr = addr_q;
   assign qspi_rd_req  = req_q;

endmodule
